// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared definitions for the byte-serial DES front/back end: the frame state
// encoding, header bit positions, block size and default core timing.
// No ports (package).
// -----------------------------------------------------------------------------
package des_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    HDR  = 3'd0,
    KEY  = 3'd1,
    DATA = 3'd2,
    KLD  = 3'd3,
    KGAP = 3'd4,
    DLD  = 3'd5,
    WAIT = 3'd6,
    OUT  = 3'd7
  } state_e;

  localparam int HDR_F         = 0;   // header bit: 1 = encrypt
  localparam int HDR_NK        = 1;   // header bit: 8 key bytes follow
  localparam int BYTES_PER_BLK = 8;
  localparam int DES_LAT_DEF   = 18;  // datin sampling edge -> etxt valid edge
  localparam int KEY_GAP_DEF   = 1;   // idle cycles between keyin and datin

  // States in which the input stream is accepted.
  function automatic logic takes_input(state_e s);
    return (s == HDR) || (s == KEY) || (s == DATA);
  endfunction

endpackage

// File: rtl/des_shift64.sv
// -----------------------------------------------------------------------------
// des_shift64
// 64-bit register used for the key, the plaintext and the result buffers.
// Priority: parallel load, then byte shift-in at the LSB, then shift-left-8.
// Ports:
//   ck, rst_n     clock, asynchronous active-low reset
//   load_i        parallel load of load_val_i
//   shin_i        shift left 8 and insert shin_byte_i at bits [7:0]
//   shl_i         shift left 8, zero fill
//   q_o           register contents
//   msb_o         bits [63:56]
// -----------------------------------------------------------------------------
module des_shift64 (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [63:0] load_val_i,
  input  logic        shin_i,
  input  logic [7:0]  shin_byte_i,
  input  logic        shl_i,
  output logic [63:0] q_o,
  output logic [7:0]  msb_o
);

  logic [63:0] data_q;

  // Register update; holds its value when no operation is requested.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 64'h0;
    end else if (load_i) begin
      data_q <= load_val_i;
    end else if (shin_i) begin
      data_q <= {data_q[55:0], shin_byte_i};
    end else if (shl_i) begin
      data_q <= {data_q[55:0], 8'h00};
    end else begin
      data_q <= data_q;
    end
  end

  assign q_o   = data_q;
  assign msb_o = data_q[63:56];

endmodule

// File: rtl/des_byte_link.sv
// -----------------------------------------------------------------------------
// des_byte_link
// Byte-serial wrapper around a 64-bit DES core. Receives a frame
// (header, optional 8 key bytes, 8 data bytes, all MSB-first), issues the
// keyin-then-datin pulse sequence to the core, captures etxt after DES_LAT
// cycles and returns it as 8 bytes, MSB-first.
// Ports:
//   ck, rst_n                  clock, asynchronous active-low reset
//   in_byte/in_valid/in_ready  input byte stream
//   out_byte/out_valid/out_ready result byte stream
//   busy                       frame in progress
//   err                        one-cycle pulse: data frame dropped, no key loaded
//   des_k/des_keyin/des_f      key, key-load pulse and direction to the core
//   des_ptxt/des_datin         data block and data-load pulse to the core
//   des_etxt                   core result
// All outputs are registered.
// -----------------------------------------------------------------------------
module des_byte_link
  import des_pkg::*;
#(
  parameter int DES_LAT = DES_LAT_DEF,
  parameter int KEY_GAP = KEY_GAP_DEF
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        err,
  output logic [63:0] des_k,
  output logic        des_keyin,
  output logic        des_f,
  output logic [63:0] des_ptxt,
  output logic        des_datin,
  input  logic [63:0] des_etxt
);

  localparam int         LAT_W     = $clog2(DES_LAT + 1);
  localparam int         GAP_W     = (KEY_GAP > 0) ? $clog2(KEY_GAP + 1) : 1;
  localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_BLK - 1);

  state_e             state_q, state_d;
  logic [2:0]         bcnt_q, bcnt_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               f_req_q, f_req_d;
  logic               nk_q, nk_d;
  logic               key_valid_q, key_valid_d;
  logic               cur_f_q, cur_f_d;
  logic               des_f_q, des_f_d;
  logic               keyin_q, datin_q, err_q, err_d;
  logic               in_ready_q, out_valid_q, busy_q;

  logic               in_acc_s, out_acc_s;
  logic               key_shin_s, ptxt_shin_s, out_load_s, out_shl_s;
  logic [7:0]         key_msb_unused_s, ptxt_msb_unused_s;
  logic [63:0]        out_q_unused_s;

  // in_ready/out_valid are registered copies of the state decode, so the
  // handshakes use the registered versions to stay consistent with the pins.
  assign in_acc_s  = in_valid && in_ready_q;
  assign out_acc_s = out_valid_q && out_ready;

  des_shift64 u_key (
    .ck(ck), .rst_n(rst_n),
    .load_i(1'b0), .load_val_i(64'h0),
    .shin_i(key_shin_s), .shin_byte_i(in_byte),
    .shl_i(1'b0),
    .q_o(des_k), .msb_o(key_msb_unused_s)
  );

  des_shift64 u_ptxt (
    .ck(ck), .rst_n(rst_n),
    .load_i(1'b0), .load_val_i(64'h0),
    .shin_i(ptxt_shin_s), .shin_byte_i(in_byte),
    .shl_i(1'b0),
    .q_o(des_ptxt), .msb_o(ptxt_msb_unused_s)
  );

  des_shift64 u_out (
    .ck(ck), .rst_n(rst_n),
    .load_i(out_load_s), .load_val_i(des_etxt),
    .shin_i(1'b0), .shin_byte_i(8'h00),
    .shl_i(out_shl_s),
    .q_o(out_q_unused_s), .msb_o(out_byte)
  );

  // Next-state, counter and shift-control decode for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    lat_d       = lat_q;
    gap_d       = gap_q;
    f_req_d     = f_req_q;
    nk_d        = nk_q;
    key_valid_d = key_valid_q;
    cur_f_d     = cur_f_q;
    des_f_d     = des_f_q;
    err_d       = 1'b0;
    key_shin_s  = 1'b0;
    ptxt_shin_s = 1'b0;
    out_load_s  = 1'b0;
    out_shl_s   = 1'b0;

    case (state_q)
      HDR: begin
        if (in_acc_s) begin
          f_req_d = in_byte[HDR_F];
          nk_d    = in_byte[HDR_NK];
          bcnt_d  = 3'd0;
          state_d = in_byte[HDR_NK] ? KEY : DATA;
        end else begin
          state_d = HDR;
        end
      end
      KEY: begin
        if (in_acc_s) begin
          key_shin_s = 1'b1;
          bcnt_d     = bcnt_q + 3'd1;
          state_d    = (bcnt_q == LAST_BYTE) ? DATA : KEY;
        end else begin
          state_d = KEY;
        end
      end
      DATA: begin
        if (in_acc_s) begin
          ptxt_shin_s = 1'b1;
          bcnt_d      = bcnt_q + 3'd1;
          if (bcnt_q != LAST_BYTE) begin
            state_d = DATA;
          end else if (!nk_q && !key_valid_q) begin
            err_d   = 1'b1;
            state_d = HDR;
          end else if (nk_q || (f_req_q != cur_f_q)) begin
            // Direction and key bookkeeping change on entry to KLD so that
            // des_f is already valid during the keyin pulse.
            des_f_d     = f_req_q;
            key_valid_d = 1'b1;
            cur_f_d     = f_req_q;
            state_d     = KLD;
          end else begin
            state_d = DLD;
          end
        end else begin
          state_d = DATA;
        end
      end
      KLD: begin
        gap_d   = '0;
        state_d = (KEY_GAP > 0) ? KGAP : DLD;
      end
      KGAP: begin
        if (int'(gap_q) + 1 >= KEY_GAP) begin
          state_d = DLD;
        end else begin
          gap_d   = gap_q + GAP_W'(1);
          state_d = KGAP;
        end
      end
      DLD: begin
        lat_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Terminal edge is the DES_LAT-th edge after the datin sampling edge.
        if (int'(lat_q) + 1 >= DES_LAT) begin
          out_load_s = 1'b1;
          bcnt_d     = 3'd0;
          state_d    = OUT;
        end else begin
          lat_d   = lat_q + LAT_W'(1);
          state_d = WAIT;
        end
      end
      OUT: begin
        if (out_acc_s) begin
          out_shl_s = 1'b1;
          bcnt_d    = bcnt_q + 3'd1;
          state_d   = (bcnt_q == LAST_BYTE) ? HDR : OUT;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = HDR;
      end
    endcase
  end

  // Sequencer state and registered outputs; pulses and handshake flags are
  // decoded from the next state so they align with the state they belong to.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HDR;
      bcnt_q      <= 3'd0;
      lat_q       <= '0;
      gap_q       <= '0;
      f_req_q     <= 1'b0;
      nk_q        <= 1'b0;
      key_valid_q <= 1'b0;
      cur_f_q     <= 1'b0;
      des_f_q     <= 1'b0;
      keyin_q     <= 1'b0;
      datin_q     <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      lat_q       <= lat_d;
      gap_q       <= gap_d;
      f_req_q     <= f_req_d;
      nk_q        <= nk_d;
      key_valid_q <= key_valid_d;
      cur_f_q     <= cur_f_d;
      des_f_q     <= des_f_d;
      keyin_q     <= (state_d == KLD);
      datin_q     <= (state_d == DLD);
      err_q       <= err_d;
      in_ready_q  <= takes_input(state_d);
      out_valid_q <= (state_d == OUT);
      busy_q      <= (state_d != HDR);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign des_keyin = keyin_q;
  assign des_datin = datin_q;
  assign des_f     = des_f_q;

endmodule
